amp3_tx: RTL and testbench
==========================

Name: amp3_tx

Overview:
- Parametrised serial audio transmitter driving Pmod AMP3 (SSM2518) in stand-alone mode; successor of the lite interface.
- Adds selectable Left-Justified or I2S framing, configurable sample width, slot width and BCLK divider.
- Adds a one-deep sample holding register with valid/ready handshake, underrun reporting, and clean frame-aligned stop.
- Sits between the audio sample source (DDS, FIFO, etc.) and the Pmod pins; everything runs in the clk domain, and BCLK is produced by an internal divider.

Parameters:
- DATA_W, 16, sample width per channel; 1 <= DATA_W <= SLOT_W-I2S_MODE.
- SLOT_W, 32, BCLK periods per channel slot; frame is 2*SLOT_W BCLK periods.
- CLK_DIV, 10, clk cycles per BCLK half-period, >= 1 (100 MHz clk -> 5 MHz BCLK).
- I2S_MODE, 0, 0 = Left-Justified (LRCLK high = left); 1 = I2S (LRCLK low = left, MSB delayed one BCLK).

Ports:
- clk  input  1  system clock, the only clock.
- rst  input  1  reset, synchronous, active-low.
- enable  input  1  run request, level-sensitive.
- dataL  input  DATA_W  left sample, two's complement, MSB first on the wire.
- dataR  input  DATA_W  right sample.
- sample_valid  input  1  dataL/dataR valid.
- sample_ready  output  1  holding register empty (combinational from register state).
- underrun  output  1  one-clk pulse: frame started with holding register empty.
- busy  output  1  state != OFF.
- SDATA  output  1  serial data to AMP3.
- BCLK  output  1  bit clock.
- LRCLK  output  1  word select.
- nSHUT  output  1  amplifier enable, high while busy.

Behaviour:
- Reset, sampled low at a clk posedge:
  - State returns to OFF on that posedge, including mid-frame.
  - Outputs: BCLK 0, SDATA 0, nSHUT 0, underrun 0, busy 0, LRCLK = left level (1 LJ / 0 I2S), sample_ready 1.
  - Holding register cleared; divider and bit counters cleared.
- Handshake:
  - A transfer happens on a clk edge where sample_valid & sample_ready. dataL and dataR are captured together; the holding register becomes full and sample_ready drops the next cycle.
  - Handshake works in every state, including OFF.
- Frame load event (FL): occurs on OFF->RUN entry and on the falling BCLK edge that starts each new frame.
  - If holding is full: the shift registers take its contents and holding becomes empty.
  - If holding is empty: the shift registers load zeros and underrun pulses for that cycle.
  - Holding status is evaluated before any same-cycle handshake. If a transfer coincides with an FL on an empty holding register, zeros are sent, underrun pulses, and the new sample stays in holding for the next frame.
- Divider:
  - Counter runs 0..CLK_DIV-1 only when busy. BCLK toggles in the cycle the counter equals CLK_DIV-1.
  - BCLK starts low on entering RUN, so the first rise comes CLK_DIV clks after entry.
- Bit timing:
  - Bit counter runs 0..2*SLOT_W-1 and advances on each BCLK falling edge.
  - SDATA and LRCLK change only on falling edges, or on entry. The AMP3 samples on the rising edge.
  - Bits 0..SLOT_W-1 form the left slot; LRCLK is at left level. Bits SLOT_W..2*SLOT_W-1 form the right slot; LRCLK is at right level.
  - LJ mode: slot bit k (k < DATA_W) carries sample bit DATA_W-1-k.
  - I2S mode: slot bit 0 carries the LSB of the previous channel. For the first frame after entry it carries 0. Sample bits then occupy slot bits 1..DATA_W.
  - All remaining slot bits are 0.
- State machine:
  - OFF: on enable=1, perform FL, set bit counter 0 and LRCLK to left level, go to RUN. nSHUT and busy rise in the same cycle.
  - RUN: frames repeat back-to-back. If enable=0, go to FINISH.
  - FINISH: the current frame completes. If enable returns to 1 before frame end, go back to RUN with no gap. At frame end (the falling edge where bit counter would wrap):
    - I2S: one extra BCLK period is sent to flush the right-channel LSB.
    - Then go to OFF, with BCLK 0, SDATA 0, nSHUT 0, LRCLK at left level.
    - The holding register keeps its content.
- Frame rate = f_clk / (4*CLK_DIV*SLOT_W).

Test Plan:
- Reset mid-frame: DATA_W=4, SLOT_W=6, CLK_DIV=2, LJ. Drop rst at bit 3 of the left slot -> next posedge gives BCLK=0, nSHUT=0, busy=0, LRCLK=1, sample_ready=1.
- LJ frame, same params: load L=4'b1010, R=4'b0111, then enable -> SDATA per BCLK period is 1,0,1,0,0,0 with LRCLK=1, then 0,1,1,1,0,0 with LRCLK=0. BCLK period is 4 clks; frame is 48 clks.
- I2S frame: I2S_MODE=1, DATA_W=4, SLOT_W=6, same samples.
  - Left slot gives 0,1,0,1,0,0 with LRCLK=0.
  - Right slot gives 0,0,1,1,1,0 with LRCLK=1.
  - Extra flush period before OFF gives SDATA=1.
- Underrun: enable with holding empty -> underrun high for exactly 1 clk at entry, first frame all zeros. A sample pushed in the same cycle is sent in frame 2 with no second underrun.
- Back-pressure: hold sample_valid=1 continuously -> exactly one transfer per frame, sample_ready low between FLs, no samples lost or duplicated across 4 frames of distinct data.
- Stop/restart:
  - Deassert enable at bit 2 -> frame completes to bit 11, then nSHUT and busy fall.
  - Deassert and reassert enable within the same frame -> no gap in BCLK and busy stays 1.

Source files
------------

// File: rtl/amp3_tx.sv
// rtl/amp3_tx.sv - Pmod AMP3 (SSM2518) serial audio transmitter, LJ or I2S framing
//
// Purpose:
//   Serialises stereo samples into BCLK/LRCLK/SDATA for an SSM2518 in stand-alone
//   mode. BCLK comes from an internal divider of clk. A one-deep holding register
//   with a valid/ready handshake decouples the sample source from frame timing.
//
// Ports:
//   clk          system clock, the only clock
//   rst          synchronous active-low reset
//   enable       run request (level)
//   dataL/dataR  left/right samples, two's complement, MSB first on the wire
//   sample_valid dataL/dataR valid
//   sample_ready holding register empty
//   underrun     one-clk pulse: frame started with holding register empty
//   busy         transmitter not OFF
//   SDATA        serial data
//   BCLK         bit clock
//   LRCLK        word select
//   nSHUT        amplifier enable, high while busy
module amp3_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int CLK_DIV  = 10,
  parameter int I2S_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] dataL,
  input  logic [DATA_W-1:0] dataR,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              underrun,
  output logic              busy,
  output logic              SDATA,
  output logic              BCLK,
  output logic              LRCLK,
  output logic              nSHUT
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int BIT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Left-slot LRCLK level: high in LJ, low in I2S.
  localparam logic LEFT_LVL = (I2S_MODE == 0);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_FINISH, S_FLUSH} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [BIT_W-1:0]  bit_q;
  logic              bclk_q, sdata_q, lrclk_q, underrun_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] hold_l_q, hold_r_q;
  logic [DATA_W-1:0] cur_l_q, cur_r_q;
  // LSB of the previous frame's right channel, sent in left-slot bit 0 in I2S.
  logic              plsb_q;

  logic              tick, fall, start, xfer;
  logic [BIT_W-1:0]  next_bit;
  logic [DATA_W-1:0] new_l, new_r;

  // Value of frame bit idx for the given channel samples.
  function automatic logic slot_bit(input logic [BIT_W-1:0] idx,
                                    input logic [DATA_W-1:0] l,
                                    input logic [DATA_W-1:0] r,
                                    input logic plsb);
    logic              right;
    int                k;
    logic [DATA_W-1:0] s;
    right = (int'(idx) >= SLOT_W);
    k = right ? int'(idx) - SLOT_W : int'(idx);
    s = right ? r : l;
    slot_bit = 1'b0;
    if (I2S_MODE == 0) begin
      for (int i = 0; i < DATA_W; i++)
        if (k == DATA_W - 1 - i) slot_bit = s[i];
    end else begin
      if (k == 0) slot_bit = right ? l[0] : plsb;
      for (int i = 0; i < DATA_W; i++)
        if (k == DATA_W - i) slot_bit = s[i];
    end
  endfunction

  assign tick     = (div_q == DIV_LAST);
  assign fall     = busy && tick && bclk_q;
  assign start    = (state_q == S_OFF) && enable;
  assign xfer     = sample_valid && !hold_full_q;
  assign next_bit = bit_q + 1'b1;
  // Frame load sees the holding state before any same-cycle transfer.
  assign new_l    = hold_full_q ? hold_l_q : '0;
  assign new_r    = hold_full_q ? hold_r_q : '0;

  assign busy         = (state_q != S_OFF);
  assign nSHUT        = busy;
  assign sample_ready = !hold_full_q;
  assign underrun     = underrun_q;
  assign SDATA        = sdata_q;
  assign BCLK         = bclk_q;
  assign LRCLK        = lrclk_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_OFF;
      div_q       <= '0;
      bit_q       <= '0;
      bclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      lrclk_q     <= LEFT_LVL;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      cur_l_q     <= '0;
      cur_r_q     <= '0;
      plsb_q      <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      // Holding register: xfer and a full-register load are mutually exclusive.
      if (xfer) begin
        hold_full_q <= 1'b1;
        hold_l_q    <= dataL;
        hold_r_q    <= dataR;
      end else if (hold_full_q && (start || (fall && bit_q == LAST_BIT &&
                                             state_q != S_FLUSH && enable))) begin
        hold_full_q <= 1'b0;
      end

      if (state_q == S_OFF) begin
        if (start) begin
          state_q    <= S_RUN;
          div_q      <= '0;
          bclk_q     <= 1'b0;
          bit_q      <= '0;
          lrclk_q    <= LEFT_LVL;
          cur_l_q    <= new_l;
          cur_r_q    <= new_r;
          plsb_q     <= 1'b0;
          underrun_q <= !hold_full_q;
          sdata_q    <= slot_bit('0, new_l, new_r, 1'b0);
        end
      end else begin
        if (state_q == S_RUN && !enable) state_q <= S_FINISH;
        if (state_q == S_FINISH && enable) state_q <= S_RUN;

        if (tick) begin
          div_q  <= '0;
          bclk_q <= !bclk_q;
        end else begin
          div_q <= div_q + 1'b1;
        end

        if (fall) begin
          if (state_q == S_FLUSH || (bit_q == LAST_BIT && !enable && I2S_MODE == 0)) begin
            state_q <= S_OFF;
            div_q   <= '0;
            bclk_q  <= 1'b0;
            bit_q   <= '0;
            sdata_q <= 1'b0;
            lrclk_q <= LEFT_LVL;
          end else if (bit_q == LAST_BIT && !enable) begin
            // I2S: one more period so the right-channel LSB reaches the amp.
            state_q <= S_FLUSH;
            sdata_q <= cur_r_q[0];
            lrclk_q <= LEFT_LVL;
          end else if (bit_q == LAST_BIT) begin
            state_q    <= S_RUN;
            bit_q      <= '0;
            lrclk_q    <= LEFT_LVL;
            cur_l_q    <= new_l;
            cur_r_q    <= new_r;
            plsb_q     <= cur_r_q[0];
            underrun_q <= !hold_full_q;
            sdata_q    <= slot_bit('0, new_l, new_r, cur_r_q[0]);
          end else begin
            bit_q   <= next_bit;
            sdata_q <= slot_bit(next_bit, cur_l_q, cur_r_q, plsb_q);
            lrclk_q <= (int'(next_bit) >= SLOT_W) ? !LEFT_LVL : LEFT_LVL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_amp3_tx.sv
// tb/tb_amp3_tx.sv - directed self-checking bench for amp3_tx (LJ and I2S instances)
`timescale 1ns/1ps
module tb_amp3_tx;

  localparam int DW = 4;
  localparam int SW = 6;
  localparam int CD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          en_lj = 1'b0, en_i2s = 1'b0;
  logic [DW-1:0] dataL = '0, dataR = '0;
  logic          sample_valid = 1'b0;

  logic lj_ready, lj_under, lj_busy, lj_sdata, lj_bclk, lj_lrclk, lj_nshut;
  logic i2_ready, i2_under, i2_busy, i2_sdata, i2_bclk, i2_lrclk, i2_nshut;

  int total = 0;
  int bad   = 0;

  amp3_tx #(.DATA_W(DW), .SLOT_W(SW), .CLK_DIV(CD), .I2S_MODE(0)) u_lj (
    .clk(clk), .rst(rst), .enable(en_lj), .dataL(dataL), .dataR(dataR),
    .sample_valid(sample_valid), .sample_ready(lj_ready), .underrun(lj_under),
    .busy(lj_busy), .SDATA(lj_sdata), .BCLK(lj_bclk), .LRCLK(lj_lrclk), .nSHUT(lj_nshut));

  amp3_tx #(.DATA_W(DW), .SLOT_W(SW), .CLK_DIV(CD), .I2S_MODE(1)) u_i2s (
    .clk(clk), .rst(rst), .enable(en_i2s), .dataL(dataL), .dataR(dataR),
    .sample_valid(sample_valid), .sample_ready(i2_ready), .underrun(i2_under),
    .busy(i2_busy), .SDATA(i2_sdata), .BCLK(i2_bclk), .LRCLK(i2_lrclk), .nSHUT(i2_nshut));

  // Expected LJ wire bit n (0..11) of a frame carrying samples l/r.
  function automatic logic lj_bit(input logic [3:0] l, input logic [3:0] r, input int n);
    logic [3:0] s;
    int k;
    s = (n >= 6) ? r : l;
    k = (n >= 6) ? n - 6 : n;
    lj_bit = 1'b0;
    if (k < 4) lj_bit = s[3 - k];
  endfunction

  task automatic do_reset();
    rst = 1'b0; en_lj = 1'b0; en_i2s = 1'b0; sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++; if (lj_bclk !== 1'b0) begin bad++; $display("FAIL rst_bclk got %b want 0", lj_bclk); end
    total++; if (lj_sdata !== 1'b0) begin bad++; $display("FAIL rst_sdata got %b want 0", lj_sdata); end
    total++; if (lj_nshut !== 1'b0) begin bad++; $display("FAIL rst_nshut got %b want 0", lj_nshut); end
    total++; if (lj_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", lj_busy); end
    total++; if (lj_under !== 1'b0) begin bad++; $display("FAIL rst_underrun got %b want 0", lj_under); end
    total++; if (lj_lrclk !== 1'b1) begin bad++; $display("FAIL rst_lrclk_lj got %b want 1", lj_lrclk); end
    total++; if (i2_lrclk !== 1'b0) begin bad++; $display("FAIL rst_lrclk_i2s got %b want 0", i2_lrclk); end
    total++; if (lj_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", lj_ready); end
    rst = 1'b1;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    dataL = 4'b1011; dataR = 4'b0001; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    en_lj = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c == 4) begin dataL = 4'b0100; sample_valid = 1'b1; end
      if (c == 5) sample_valid = 1'b0;
      if (c == 13) begin
        total++; if (lj_sdata !== 1'b1) begin bad++; $display("FAIL mid_sdata_bit3 got %b want 1", lj_sdata); end
        total++; if (lj_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_full got %b want 0", lj_ready); end
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (lj_bclk !== 1'b0) begin bad++; $display("FAIL mid_rst_bclk got %b want 0", lj_bclk); end
    total++; if (lj_nshut !== 1'b0) begin bad++; $display("FAIL mid_rst_nshut got %b want 0", lj_nshut); end
    total++; if (lj_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", lj_busy); end
    total++; if (lj_lrclk !== 1'b1) begin bad++; $display("FAIL mid_rst_lrclk got %b want 1", lj_lrclk); end
    total++; if (lj_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got %b want 1", lj_ready); end
    total++; if (lj_sdata !== 1'b0) begin bad++; $display("FAIL mid_rst_sdata got %b want 0", lj_sdata); end
    en_lj = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_lj_frame();
    logic [5:0] exp_l, exp_r;
    logic       e;
    exp_l = 6'b101000;
    exp_r = 6'b011100;
    do_reset();
    dataL = 4'b1010; dataR = 4'b0111; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    total++; if (lj_ready !== 1'b0) begin bad++; $display("FAIL lj_ready_after_push got %b want 0", lj_ready); end
    en_lj = 1'b1;
    for (int c = 0; c <= 96; c++) begin
      @(negedge clk);
      if (c < 48) begin
        e = ((c % 4) >= 2);
        total++; if (lj_bclk !== e) begin bad++; $display("FAIL lj_bclk c=%0d got %b want %b", c, lj_bclk, e); end
        if (c % 4 == 2) begin
          e = (c < 24) ? exp_l[5 - c / 4] : exp_r[5 - (c - 24) / 4];
          total++; if (lj_sdata !== e) begin bad++; $display("FAIL lj_sdata c=%0d got %b want %b", c, lj_sdata, e); end
          e = (c < 24);
          total++; if (lj_lrclk !== e) begin bad++; $display("FAIL lj_lrclk c=%0d got %b want %b", c, lj_lrclk, e); end
        end
      end
      if (c == 0) begin
        total++; if (lj_busy !== 1'b1 || lj_nshut !== 1'b1) begin bad++; $display("FAIL lj_entry_busy got %b%b want 11", lj_busy, lj_nshut); end
        total++; if (lj_under !== 1'b0) begin bad++; $display("FAIL lj_entry_underrun got %b want 0", lj_under); end
        total++; if (lj_ready !== 1'b1) begin bad++; $display("FAIL lj_entry_ready got %b want 1", lj_ready); end
      end
      if (c == 48) begin
        total++; if (lj_under !== 1'b1) begin bad++; $display("FAIL lj_frame2_underrun got %b want 1", lj_under); end
        total++; if (lj_lrclk !== 1'b1) begin bad++; $display("FAIL lj_frame2_lrclk got %b want 1", lj_lrclk); end
        en_lj = 1'b0;
      end
      if (c == 49) begin
        total++; if (lj_under !== 1'b0) begin bad++; $display("FAIL lj_underrun_width got %b want 0", lj_under); end
      end
      if (c == 95) begin
        total++; if (lj_busy !== 1'b1) begin bad++; $display("FAIL lj_busy_last got %b want 1", lj_busy); end
      end
      if (c == 96) begin
        total++; if (lj_busy !== 1'b0 || lj_nshut !== 1'b0) begin bad++; $display("FAIL lj_off got %b%b want 00", lj_busy, lj_nshut); end
        total++; if (lj_bclk !== 1'b0 || lj_sdata !== 1'b0 || lj_lrclk !== 1'b1) begin
          bad++; $display("FAIL lj_off_pins got bclk=%b sdata=%b lrclk=%b want 0 0 1", lj_bclk, lj_sdata, lj_lrclk); end
      end
    end
  endtask

  task automatic test_i2s_frame();
    logic [5:0] exp_l, exp_r;
    logic       e;
    exp_l = 6'b010100;
    exp_r = 6'b001110;
    do_reset();
    dataL = 4'b1010; dataR = 4'b0111; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    en_i2s = 1'b1;
    for (int c = 0; c <= 52; c++) begin
      @(negedge clk);
      if (c < 48 && c % 4 == 2) begin
        e = (c < 24) ? exp_l[5 - c / 4] : exp_r[5 - (c - 24) / 4];
        total++; if (i2_sdata !== e) begin bad++; $display("FAIL i2s_sdata c=%0d got %b want %b", c, i2_sdata, e); end
        e = (c >= 24);
        total++; if (i2_lrclk !== e) begin bad++; $display("FAIL i2s_lrclk c=%0d got %b want %b", c, i2_lrclk, e); end
        total++; if (i2_bclk !== 1'b1) begin bad++; $display("FAIL i2s_bclk c=%0d got %b want 1", c, i2_bclk); end
      end
      if (c == 0) begin
        total++; if (i2_busy !== 1'b1 || i2_lrclk !== 1'b0) begin bad++; $display("FAIL i2s_entry got busy=%b lrclk=%b want 1 0", i2_busy, i2_lrclk); end
      end
      if (c == 2) en_i2s = 1'b0;
      if (c == 48) begin
        total++; if (i2_busy !== 1'b1) begin bad++; $display("FAIL i2s_flush_busy got %b want 1", i2_busy); end
        total++; if (i2_sdata !== 1'b1) begin bad++; $display("FAIL i2s_flush_sdata got %b want 1", i2_sdata); end
        total++; if (i2_lrclk !== 1'b0) begin bad++; $display("FAIL i2s_flush_lrclk got %b want 0", i2_lrclk); end
      end
      if (c == 50) begin
        total++; if (i2_bclk !== 1'b1) begin bad++; $display("FAIL i2s_flush_bclk got %b want 1", i2_bclk); end
      end
      if (c == 51) begin
        total++; if (i2_busy !== 1'b1) begin bad++; $display("FAIL i2s_flush_busy2 got %b want 1", i2_busy); end
      end
      if (c == 52) begin
        total++; if (i2_busy !== 1'b0 || i2_nshut !== 1'b0) begin bad++; $display("FAIL i2s_off got %b%b want 00", i2_busy, i2_nshut); end
        total++; if (i2_sdata !== 1'b0 || i2_bclk !== 1'b0 || i2_lrclk !== 1'b0) begin
          bad++; $display("FAIL i2s_off_pins got sdata=%b bclk=%b lrclk=%b want 0 0 0", i2_sdata, i2_bclk, i2_lrclk); end
      end
    end
  endtask

  task automatic test_underrun();
    logic e;
    do_reset();
    dataL = 4'b1100; dataR = 4'b0011; sample_valid = 1'b1;
    en_lj = 1'b1;
    for (int c = 0; c <= 96; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (lj_under !== 1'b1) begin bad++; $display("FAIL ur_entry_pulse got %b want 1", lj_under); end
        total++; if (lj_ready !== 1'b0) begin bad++; $display("FAIL ur_held_sample got %b want 0", lj_ready); end
        sample_valid = 1'b0;
      end else if (c < 96) begin
        total++; if (lj_under !== 1'b0) begin bad++; $display("FAIL ur_no_pulse c=%0d got %b want 0", c, lj_under); end
      end
      if (c < 96 && c % 4 == 2) begin
        e = (c < 48) ? 1'b0 : lj_bit(4'b1100, 4'b0011, (c - 48) / 4);
        total++; if (lj_sdata !== e) begin bad++; $display("FAIL ur_sdata c=%0d got %b want %b", c, lj_sdata, e); end
      end
      if (c == 48) begin
        total++; if (lj_ready !== 1'b1) begin bad++; $display("FAIL ur_frame2_ready got %b want 1", lj_ready); end
        en_lj = 1'b0;
      end
      if (c == 96) begin
        total++; if (lj_busy !== 1'b0) begin bad++; $display("FAIL ur_off got %b want 0", lj_busy); end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [3:0] sl [5];
    logic [3:0] sr [5];
    int         idx;
    logic       pend, e;
    sl = '{4'b1001, 4'b0101, 4'b1110, 4'b0011, 4'b1000};
    sr = '{4'b0110, 4'b1010, 4'b0001, 4'b1101, 4'b0111};
    do_reset();
    idx = 0;
    dataL = sl[0]; dataR = sr[0]; sample_valid = 1'b1;
    @(negedge clk);
    idx = 1; dataL = sl[1]; dataR = sr[1];
    total++; if (lj_ready !== 1'b0) begin bad++; $display("FAIL bp_first_push got %b want 0", lj_ready); end
    en_lj = 1'b1;
    pend = 1'b0;
    for (int c = 0; c <= 192; c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (idx == 4) sample_valid = 1'b0;
        else begin idx++; dataL = sl[idx]; dataR = sr[idx]; end
      end
      if (c < 192) begin
        e = (c % 48 == 0);
        total++; if (lj_ready !== e) begin bad++; $display("FAIL bp_ready c=%0d got %b want %b", c, lj_ready, e); end
        if (lj_ready && sample_valid) pend = 1'b1;
        total++; if (lj_under !== 1'b0) begin bad++; $display("FAIL bp_underrun c=%0d got %b want 0", c, lj_under); end
        if (c % 4 == 2) begin
          e = lj_bit(sl[c / 48], sr[c / 48], (c % 48) / 4);
          total++; if (lj_sdata !== e) begin bad++; $display("FAIL bp_sdata c=%0d got %b want %b", c, lj_sdata, e); end
        end
      end
      if (c == 190) en_lj = 1'b0;
      if (c == 192) begin
        total++; if (lj_busy !== 1'b0) begin bad++; $display("FAIL bp_off got %b want 0", lj_busy); end
        total++; if (lj_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_kept got %b want 0", lj_ready); end
      end
    end
  endtask

  task automatic test_stop_restart();
    logic e;
    do_reset();
    dataL = 4'b1111; dataR = 4'b0000; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    en_lj = 1'b1;
    for (int c = 0; c <= 48; c++) begin
      @(negedge clk);
      if (c == 8) en_lj = 1'b0;
      if (c == 46) begin
        total++; if (lj_busy !== 1'b1 || lj_lrclk !== 1'b0) begin bad++; $display("FAIL stop_bit11 got busy=%b lrclk=%b want 1 0", lj_busy, lj_lrclk); end
      end
      if (c == 47) begin
        total++; if (lj_nshut !== 1'b1) begin bad++; $display("FAIL stop_nshut_held got %b want 1", lj_nshut); end
      end
      if (c == 48) begin
        total++; if (lj_busy !== 1'b0 || lj_nshut !== 1'b0) begin bad++; $display("FAIL stop_off got %b%b want 00", lj_busy, lj_nshut); end
      end
    end

    do_reset();
    en_lj = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c == 10) en_lj = 1'b0;
      if (c == 20) en_lj = 1'b1;
      e = ((c % 4) >= 2);
      total++; if (lj_bclk !== e || lj_busy !== 1'b1) begin
        bad++; $display("FAIL restart_gap c=%0d got bclk=%b busy=%b want %b 1", c, lj_bclk, lj_busy, e); end
    end
    en_lj = 1'b0;
    repeat (50) @(negedge clk);
    total++; if (lj_busy !== 1'b0) begin bad++; $display("FAIL restart_stop got %b want 0", lj_busy); end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_lj_frame();
    test_i2s_frame();
    test_underrun();
    test_back_pressure();
    test_stop_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
